// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and round-function helpers.
package aes_pkg;

  localparam int unsigned AES128_ROUNDS = 10;
  localparam int unsigned ROUND_W       = 4;
  localparam logic [7:0]  GF_POLY       = 8'h1B;

  // state[row][col] of bytes
  typedef logic [3:0][3:0][7:0] aes_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_WAIT,
    ST_FETCH,
    ST_APPLY,
    ST_DONE
  } aes_fsm_e;

  // Multiply by {02} in GF(2^8)
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Row r rotates left by r
  function automatic aes_state_t shift_rows(input aes_state_t s);
    aes_state_t o;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        o[2'(r)][2'(c)] = s[2'(r)][2'(c + r)];
      end
    end
    return o;
  endfunction

  // {02,03,01,01} circulant applied to each column
  function automatic aes_state_t mix_columns(input aes_state_t s);
    aes_state_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[2'(r)][2'(c)] = xtime(s[2'(r)][2'(c)])
                        ^ xtime(s[2'(r + 1)][2'(c)]) ^ s[2'(r + 1)][2'(c)]
                        ^ s[2'(r + 2)][2'(c)]
                        ^ s[2'(r + 3)][2'(c)];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup.
module aes_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] sbox_c_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sbox_c_o = SBOX[byte_i];

endmodule

// File: rtl/aes_cipher_round_ctrl.sv
// Iterative AES-128 encryption: one round per fetched round key.
module aes_cipher_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned KEY_LAT = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  aes_state_t         plaintext,
  input  logic               key_rdy,
  input  aes_state_t         round_key,
  output logic               encrypt_en,
  output logic [ROUND_W-1:0] key_sel,
  output logic               busy,
  output logic               done,
  output logic               err,
  output aes_state_t         ciphertext
);

  localparam logic [1:0]         FETCH_LAST = 2'(KEY_LAT - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(AES128_ROUNDS);

  aes_fsm_e           state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [1:0]         wait_q, wait_d;
  aes_state_t         aes_q, aes_d;
  aes_state_t         ct_q, ct_d;
  logic               enc_q, enc_d;
  logic [ROUND_W-1:0] ksel_q, ksel_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  aes_state_t         sb_c, sr_c, mc_c, round_c;
  logic               abort_c;

  // SubBytes: one S-box per state byte
  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 4; gc++) begin : g_col
      aes_sbox u_sbox (
        .byte_i   (aes_q[gr][gc]),
        .sbox_c_o (sb_c[gr][gc])
      );
    end
  end

  // Round datapath: initial AddRoundKey, full rounds, final round without MixColumns
  always_comb begin
    sr_c    = shift_rows(sb_c);
    mc_c    = mix_columns(sr_c);
    round_c = mc_c ^ round_key;
    if (round_q == '0) begin
      round_c = aes_q ^ round_key;
    end else if (round_q == LAST_ROUND) begin
      round_c = sr_c ^ round_key;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    wait_d  = wait_q;
    aes_d   = aes_q;
    ct_d    = ct_q;
    enc_d   = enc_q;
    ksel_d  = ksel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    abort_c = ((state_q == ST_FETCH) || (state_q == ST_APPLY)) && !key_rdy;

    if (abort_c) begin
      // Expander lost its keys: drop the operation, keep the old ciphertext
      err_d   = 1'b1;
      enc_d   = 1'b0;
      ksel_d  = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            aes_d   = plaintext;
            enc_d   = 1'b1;
            round_d = '0;
            state_d = ST_KEY_WAIT;
          end
        end
        ST_KEY_WAIT: begin
          if (key_rdy) begin
            ksel_d  = round_q;
            wait_d  = '0;
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (wait_q == FETCH_LAST) begin
            state_d = ST_APPLY;
          end else begin
            wait_d = wait_q + 2'd1;
          end
        end
        ST_APPLY: begin
          aes_d = round_c;
          if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 4'd1;
            ksel_d  = round_q + 4'd1;
            wait_d  = '0;
            state_d = ST_FETCH;
          end
        end
        ST_DONE: begin
          // Dropping encrypt_en makes the expander regenerate keys next time
          ct_d    = aes_q;
          done_d  = 1'b1;
          enc_d   = 1'b0;
          ksel_d  = '0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      wait_q  <= '0;
      aes_q   <= '0;
      ct_q    <= '0;
      enc_q   <= 1'b0;
      ksel_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      wait_q  <= wait_d;
      aes_q   <= aes_d;
      ct_q    <= ct_d;
      enc_q   <= enc_d;
      ksel_q  <= ksel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign encrypt_en = enc_q;
  assign key_sel    = ksel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_cipher_round_ctrl.sv
// Bench for aes_cipher_round_ctrl: known-answer and random vectors against a byte-level AES model.
module tb_aes_cipher_round_ctrl;
  import aes_pkg::*;

  localparam int unsigned KL_A = 1;
  localparam int unsigned KL_B = 3;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       key_rdy = 1'b0;
  aes_state_t plaintext = '0;
  aes_state_t rk_a = '0, rk_b = '0, pb1 = '0, pb2 = '0;
  logic       enc_a, enc_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [3:0] ksel_a, ksel_b;
  aes_state_t ct_a, ct_b;

  logic [7:0]   sbox_ref [256];
  logic [127:0] rkeys [11];
  logic [3:0]   ksel_max = '0;
  int unsigned  n_tests = 0;
  int unsigned  n_fail = 0;

  always #5 clk = ~clk;

  aes_cipher_round_ctrl #(.KEY_LAT(KL_A)) u_dut_a (
    .clk(clk), .resetn(resetn), .start(start), .plaintext(plaintext),
    .key_rdy(key_rdy), .round_key(rk_a), .encrypt_en(enc_a), .key_sel(ksel_a),
    .busy(busy_a), .done(done_a), .err(err_a), .ciphertext(ct_a)
  );

  aes_cipher_round_ctrl #(.KEY_LAT(KL_B)) u_dut_b (
    .clk(clk), .resetn(resetn), .start(start), .plaintext(plaintext),
    .key_rdy(1'b1), .round_key(rk_b), .encrypt_en(enc_b), .key_sel(ksel_b),
    .busy(busy_b), .done(done_b), .err(err_b), .ciphertext(ct_b)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      for (int k = 1; k <= 4; k++) begin
        t = (inv << k) | (inv >> (8 - k));
        s = s ^ t;
      end
      sbox_ref[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
  endfunction

  task automatic set_key(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] out;
    for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8] ^ rkeys[0][127 - 8*n -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int n = 0; n < 16; n++) s[n] = sbox_ref[s[n]];
      for (int n = 0; n < 16; n++) t[n] = s[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)];
      for (int c = 0; c < 4; c++) begin
        for (int i = 0; i < 4; i++) a[i] = t[4*c + i];
        for (int i = 0; i < 4; i++) begin
          if (rnd < 10)
            s[4*c + i] = gmul(8'h02, a[i]) ^ gmul(8'h03, a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
          else
            s[4*c + i] = a[i];
        end
      end
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ rkeys[rnd][127 - 8*n -: 8];
    end
    for (int n = 0; n < 16; n++) out[127 - 8*n -: 8] = s[n];
    return out;
  endfunction

  function automatic aes_state_t to_state(input logic [127:0] v);
    aes_state_t s;
    for (int n = 0; n < 16; n++) s[2'(n % 4)][2'(n / 4)] = v[127 - 8*n -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input aes_state_t s);
    logic [127:0] v;
    for (int n = 0; n < 16; n++) v[127 - 8*n -: 8] = s[2'(n % 4)][2'(n / 4)];
    return v;
  endfunction

  // Behavioural key expanders: registered, KL_A and KL_B cycles from key_sel
  always @(posedge clk) begin
    rk_a <= (ksel_a <= 4'd10) ? to_state(rkeys[int'(ksel_a)]) : '0;
    pb1  <= (ksel_b <= 4'd10) ? to_state(rkeys[int'(ksel_b)]) : '0;
    pb2  <= pb1;
    rk_b <= pb2;
  end

  always @(negedge clk) begin
    if (ksel_a > ksel_max) ksel_max = ksel_a;
    if (ksel_b > ksel_max) ksel_max = ksel_b;
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ksel(input logic [3:0] v, input string tag);
    int found;
    found = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (ksel_a == v) begin found = 1; break; end
    end
    check_eq(tag, 128'(found), 128'd1);
  endtask

  // One encryption on DUT A; d = cycles key_rdy is held low after start is accepted
  task automatic run_op(input string tag, input logic [127:0] key, input logic [127:0] pt,
                        input logic [127:0] exp, input int d, input bit glitch, input bit chk_ksel);
    int           lat, errs;
    logic [3:0]   last;
    logic [127:0] seq_got, seq_exp;
    set_key(key);
    plaintext = to_state(pt);
    key_rdy   = (d == 0);
    start     = 1'b1;
    tick();
    start   = 1'b0;
    lat     = 0;
    errs    = 0;
    last    = ksel_a;
    seq_got = 128'(last);
    for (int n = 1; n <= 400; n++) begin
      tick();
      if (n == d) key_rdy = 1'b1;
      if (glitch && n == 6) begin plaintext = ~plaintext; start = 1'b1; end
      if (glitch && n == 7) start = 1'b0;
      if (err_a) errs++;
      if (ksel_a != last) begin last = ksel_a; seq_got = (seq_got << 4) | 128'(last); end
      if (done_a) begin lat = n; break; end
    end
    check_eq({tag, "_lat"}, 128'(lat), 128'(d + 2 + 11 * (KL_A + 1)));
    check_eq({tag, "_ct"}, from_state(ct_a), exp);
    check_eq({tag, "_busy_at_done"}, 128'(busy_a), 128'd0);
    check_eq({tag, "_enc_at_done"}, 128'(enc_a), 128'd0);
    check_eq({tag, "_no_err"}, 128'(errs), 128'd0);
    if (chk_ksel) begin
      seq_exp = '0;
      for (int i = 0; i <= 10; i++) seq_exp = (seq_exp << 4) | 128'(i);
      seq_exp = seq_exp << 4;
      check_eq({tag, "_ksel_seq"}, seq_got, seq_exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k, p, e, prev;
    int           la, lb, dn, first, gap, dones, errs;

    build_sbox();

    // Reset values
    key_rdy = 1'b1;
    tick();
    tick();
    check_eq("rst_enc", 128'(enc_a), 128'd0);
    check_eq("rst_ksel", 128'(ksel_a), 128'd0);
    check_eq("rst_busy", 128'(busy_a), 128'd0);
    check_eq("rst_done", 128'(done_a), 128'd0);
    check_eq("rst_err", 128'(err_a), 128'd0);
    check_eq("rst_ct", from_state(ct_a), 128'd0);
    resetn = 1'b1;
    tick();

    // App. B on both key latencies at once
    set_key(KEY_B);
    plaintext = to_state(PT_B);
    start = 1'b1;
    tick();
    start = 1'b0;
    la = 0;
    lb = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (done_a && la == 0) la = n;
      if (done_b && lb == 0) lb = n;
      if (la != 0 && lb != 0) break;
    end
    check_eq("dual_lat_a", 128'(la), 128'(2 + 11 * (KL_A + 1)));
    check_eq("dual_lat_b", 128'(lb), 128'(2 + 11 * (KL_B + 1)));
    check_eq("dual_ct_a", from_state(ct_a), CT_B);
    check_eq("dual_ct_b", from_state(ct_b), CT_B);
    check_eq("dual_err_b", 128'(err_b), 128'd0);
    tick();

    // Known answers, key_sel sequence, repeat with the same key
    run_op("appB", KEY_B, PT_B, CT_B, 0, 1'b0, 1'b1);
    run_op("appC_1", KEY_C, PT_C, CT_C, 0, 1'b0, 1'b0);
    run_op("appC_2", KEY_C, PT_C, CT_C, 0, 1'b0, 1'b0);

    // Random vectors, random key_rdy delay, mid-op start on odd iterations
    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      set_key(k);
      e = aes_ref(p);
      run_op($sformatf("rand%0d", i), k, p, e, int'($urandom_range(0, 6)), i[0], 1'b0);
    end

    // key_rdy lost in round 5 FETCH
    prev = from_state(ct_a);
    set_key({$urandom, $urandom, $urandom, $urandom});
    plaintext = to_state({$urandom, $urandom, $urandom, $urandom});
    key_rdy = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ksel(4'd5, "abort_reach_r5");
    key_rdy = 1'b0;
    tick();
    check_eq("abort_err", 128'(err_a), 128'd1);
    check_eq("abort_busy", 128'(busy_a), 128'd0);
    check_eq("abort_done", 128'(done_a), 128'd0);
    check_eq("abort_enc", 128'(enc_a), 128'd0);
    tick();
    check_eq("abort_err_pulse", 128'(err_a), 128'd0);
    key_rdy = 1'b1;
    dones = 0;
    errs  = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (done_a) dones++;
      if (err_a) errs++;
    end
    check_eq("abort_no_done", 128'(dones), 128'd0);
    check_eq("abort_no_err", 128'(errs), 128'd0);
    check_eq("abort_ct_held", from_state(ct_a), prev);

    // Reset during round 7 APPLY
    set_key(KEY_B);
    plaintext = to_state(PT_B);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ksel(4'd7, "rst_reach_r7");
    tick();
    resetn = 1'b0;
    #1;
    check_eq("midrst_enc", 128'(enc_a), 128'd0);
    check_eq("midrst_ksel", 128'(ksel_a), 128'd0);
    check_eq("midrst_busy", 128'(busy_a), 128'd0);
    check_eq("midrst_done", 128'(done_a), 128'd0);
    check_eq("midrst_err", 128'(err_a), 128'd0);
    check_eq("midrst_ct", from_state(ct_a), 128'd0);
    tick();
    resetn = 1'b1;
    tick();
    run_op("appB_after_rst", KEY_B, PT_B, CT_B, 0, 1'b0, 1'b0);

    // start held high: back-to-back operations
    set_key(KEY_B);
    plaintext = to_state(PT_B);
    key_rdy = 1'b1;
    start = 1'b1;
    dn = 0;
    first = 0;
    gap = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (dn == 1 && n == first + 1) check_eq("b2b_busy_after_idle", 128'(busy_a), 128'd1);
      if (done_a) begin
        check_eq($sformatf("b2b_ct%0d", dn), from_state(ct_a), CT_B);
        check_eq($sformatf("b2b_idle%0d", dn), 128'(busy_a), 128'd0);
        if (dn == 0) first = n;
        else gap = n - first;
        dn++;
        if (dn == 2) begin start = 1'b0; break; end
      end
    end
    start = 1'b0;
    check_eq("b2b_count", 128'(dn), 128'd2);
    check_eq("b2b_gap", 128'(gap), 128'(3 + 11 * (KL_A + 1)));

    check_eq("ksel_in_range", 128'(ksel_max > 4'd10), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
